adc_stream_source: RTL

Serial-ADC front end that periodically triggers a conversion on an external SPI-style ADC, shifts the result in, buffers it in a small FIFO, and presents it as a ready/valid sample stream. It drives the CNN input stream (`cnn_valid_in` / `cnn_data_in`, honouring `cnn_ready_in`) and is the producer end of that interface. It also reports samples lost to FIFO overflow.

---
 rtl/adc_stream_source.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/adc_stream_source.sv
// adc_stream_source: periodic serial-ADC capture into a FWFT FIFO, presented as a ready/valid sample stream
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   adc_enable                         runs the sample timer
//   adc_convst, adc_cs_n, adc_sclk     ADC control (SPI mode 0)
//   adc_sdo                            ADC serial data, MSB first
//   adc_sample_ready_out/_valid_out    stream handshake (producer side)
//   adc_sample_data_out                FIFO head
//   adc_overflow, adc_drop_count       sticky drop flag, saturating drop counter
//   adc_drop_clear                     synchronous clear of the drop status
module adc_stream_source #(
    parameter int DATA_WIDTH    = 12,
    parameter int SCLK_DIV      = 4,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_enable,
    output logic                  adc_convst,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_sdo,
    input  logic                  adc_sample_ready_out,
    output logic                  adc_sample_valid_out,
    output logic [DATA_WIDTH-1:0] adc_sample_data_out,
    output logic                  adc_overflow,
    output logic [15:0]           adc_drop_count,
    input  logic                  adc_drop_clear
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(CONV_CYCLES + SCLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         tcnt;
    logic                  tick;
    logic [CW-1:0]         cnt;
    logic                  phase;
    logic                  half_end;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  push, pop, wr, full, drop;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           occ;

    assign tick = adc_enable && tcnt == TW'(SAMPLE_PERIOD - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else
            tcnt <= (!adc_enable || tick) ? '0 : tcnt + TW'(1);
    end

    assign half_end = cnt == CW'(SCLK_DIV - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = tick ? CONV : IDLE;
            CONV:    state_n = cnt == CW'(CONV_CYCLES - 1) ? SHIFT : CONV;
            SHIFT:   state_n = (phase && half_end && bit_cnt == BW'(DATA_WIDTH - 1)) ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
        adc_convst = state == CONV && cnt == '0;
        adc_cs_n   = state != SHIFT;
        adc_sclk   = state == SHIFT && phase;
        push       = state == DONE;
    end

    // cnt times CONV and each SCLK half-period; phase=1 is the high half.
    // adc_sdo is captured at the end of each low half, i.e. on the edge where SCLK rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sreg    <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt     <= '0;
                phase   <= 1'b0;
                bit_cnt <= '0;
            end else if (state == SHIFT && half_end) begin
                cnt   <= '0;
                phase <= ~phase;
                if (phase)
                    bit_cnt <= bit_cnt + BW'(1);
                else
                    sreg <= {sreg[DATA_WIDTH-2:0], adc_sdo};
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign full                 = occ == (AW+1)'(FIFO_DEPTH);
    assign adc_sample_valid_out = occ != '0;
    assign adc_sample_data_out  = adc_sample_valid_out ? mem[rd_ptr] : '0;
    assign pop                  = adc_sample_valid_out && adc_sample_ready_out;
    assign wr                   = push && (!full || pop);
    assign drop                 = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= sreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end

    // A drop wins over a simultaneous clear: the counter restarts at 1 and the flag stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc_overflow   <= 1'b0;
            adc_drop_count <= '0;
        end else if (drop) begin
            adc_overflow   <= 1'b1;
            adc_drop_count <= adc_drop_clear ? 16'd1 :
                              (adc_drop_count == 16'hFFFF) ? adc_drop_count : adc_drop_count + 16'd1;
        end else if (adc_drop_clear) begin
            adc_overflow   <= 1'b0;
            adc_drop_count <= '0;
        end
    end
endmodule
